// File: rtl/mux_n_pipe.sv
// N-way operand select followed by a 1- or 2-stage registered pipeline.
// Each stage carries a valid bit; a single stall freezes the whole pipe,
// flush kills every valid bit, and sel_err latches an accepted illegal select.
module mux_n_pipe #(
  parameter int                 DataBit  = 32,
  parameter int                 NumIn    = 4,
  parameter int                 SelBit   = 2,
  parameter int                 Latency  = 1,
  parameter logic [DataBit-1:0] ResetVal = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NumIn*DataBit-1:0] in_bus,
  input  logic [SelBit-1:0]        sel,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic [DataBit-1:0]       out,
  output logic                     out_valid,
  output logic                     sel_err
);

  if ((Latency != 1) && (Latency != 2)) begin : g_bad_latency
    $error("mux_n_pipe: Latency must be 1 or 2");
  end
  if ((NumIn < 2) || (NumIn > 16)) begin : g_bad_numin
    $error("mux_n_pipe: NumIn must be in 2..16");
  end
  if ((2 ** SelBit) < NumIn) begin : g_bad_selbit
    $error("mux_n_pipe: SelBit too narrow for NumIn");
  end

  logic [DataBit-1:0] pick;
  logic               sel_legal;

  logic [DataBit-1:0] data_p1_q, data_p1_d;
  logic               vld_p1_q,  vld_p1_d;

  logic               err_q, err_d;
  logic               err_set;

  // Operand select; out-of-range selects fall back to ResetVal
  always_comb begin
    pick      = ResetVal;
    sel_legal = 1'b0;
    for (int k = 0; k < NumIn; k++) begin
      if (int'(sel) == k) begin
        pick      = in_bus[k*DataBit +: DataBit];
        sel_legal = 1'b1;
      end
    end
  end

  // ---- stage 1 boundary ----
  // Stage 1 next state: flush clears valid (data still moves unless stalled), stall holds
  always_comb begin
    data_p1_d = data_p1_q;
    vld_p1_d  = vld_p1_q;
    if (flush) begin
      vld_p1_d = 1'b0;
      if (!stall) data_p1_d = pick;
    end else if (!stall) begin
      data_p1_d = pick;
      vld_p1_d  = in_valid;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1_q <= ResetVal;
      vld_p1_q  <= 1'b0;
    end else begin
      data_p1_q <= data_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  if (Latency == 2) begin : g_lat2
    logic [DataBit-1:0] data_p2_q, data_p2_d;
    logic               vld_p2_q,  vld_p2_d;

    // ---- stage 2 boundary ----
    // Stage 2 next state: same rules as stage 1, fed from stage 1
    always_comb begin
      data_p2_d = data_p2_q;
      vld_p2_d  = vld_p2_q;
      if (flush) begin
        vld_p2_d = 1'b0;
        if (!stall) data_p2_d = data_p1_q;
      end else if (!stall) begin
        data_p2_d = data_p1_q;
        vld_p2_d  = vld_p1_q;
      end
    end

    // Stage 2 registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_p2_q <= ResetVal;
        vld_p2_q  <= 1'b0;
      end else begin
        data_p2_q <= data_p2_d;
        vld_p2_q  <= vld_p2_d;
      end
    end

    assign out       = data_p2_q;
    assign out_valid = vld_p2_q;
  end else begin : g_lat1
    assign out       = data_p1_q;
    assign out_valid = vld_p1_q;
  end

  // Sticky error: an illegal select only counts when it is actually accepted
  assign err_set = in_valid & ~stall & ~flush & ~sel_legal;

  // Error next state: set has priority over clear
  always_comb begin
    err_d = err_q;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign sel_err = err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: three instances share one stimulus stream.
//   inst 0: NumIn=3, Latency=1, ResetVal=0
//   inst 1: NumIn=3, Latency=2, ResetVal=5A5A0001
//   inst 2: NumIn=4, Latency=2, ResetVal=DEADBEEF (every select legal)
module tb_mux_n_pipe;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] bus4;
  logic [1:0]   sel;
  logic         in_valid, stall, flush, err_clr;

  logic [31:0]  out_w [3];
  logic         ov_w  [3];
  logic         se_w  [3];

  int checks = 0;
  int errors = 0;

  // Reference model state: advance count (non-stalled edges), flush count,
  // per-instance queue of accepted-but-not-yet-presented operands, error flag.
  int   adv  = 0;
  int   fseq = 0;
  exp_t q [3][$];
  logic err_m [3];

  mux_n_pipe #(.DataBit(32), .NumIn(3), .SelBit(2), .Latency(1), .ResetVal(32'h0000_0000)) u_i0 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus4[95:0]), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out(out_w[0]), .out_valid(ov_w[0]), .sel_err(se_w[0]));

  mux_n_pipe #(.DataBit(32), .NumIn(3), .SelBit(2), .Latency(2), .ResetVal(32'h5A5A_0001)) u_i1 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus4[95:0]), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out(out_w[1]), .out_valid(ov_w[1]), .sel_err(se_w[1]));

  mux_n_pipe #(.DataBit(32), .NumIn(4), .SelBit(2), .Latency(2), .ResetVal(32'hDEAD_BEEF)) u_i2 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus4), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out(out_w[2]), .out_valid(ov_w[2]), .sel_err(se_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int numin(input int i);
    return (i == 2) ? 4 : 3;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] rv(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h5A5A_0001;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] ref_pick(input int i, input logic [1:0] s, input logic [127:0] b);
    if (int'(s) < numin(i)) return b[int'(s)*32 +: 32];
    return rv(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_out%0d", tag, i), out_w[i], rv(i));
      chk($sformatf("%s_ov%0d", tag, i), {31'd0, ov_w[i]}, 32'd0);
      chk($sformatf("%s_err%0d", tag, i), {31'd0, se_w[i]}, 32'd0);
    end
  endtask

  // Model update for one rising edge, from the inputs presented at that edge
  task automatic model_edge();
    exp_t e;
    if (!rst_n) return;
    if (!stall) adv++;
    if (flush) fseq++;
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        q[i].delete();
      end else if (!stall && in_valid) begin
        e.data = ref_pick(i, sel, bus4);
        e.due  = adv + lat(i) - 1;
        q[i].push_back(e);
      end
      if (!stall && !flush && in_valid && (int'(sel) >= numin(i))) err_m[i] = 1'b1;
      else if (err_clr)                                             err_m[i] = 1'b0;
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] s, input logic st,
                     input logic fl, input logic ec);
    in_valid = v; sel = s; stall = st; flush = fl; err_clr = ec;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      err_m[i] = 1'b0;
    end
    #1 chk_reset_state("async_rst");
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: each falling edge, compare DUT outputs with the scoreboard
  initial begin : monitor
    logic        ev_last [3];
    logic [31:0] ed_last [3];
    int          last_adv;
    int          last_fseq;
    for (int i = 0; i < 3; i++) begin
      ev_last[i] = 1'b0;
      ed_last[i] = '0;
    end
    last_adv  = 0;
    last_fseq = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) ev_last[i] = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (adv != last_adv) begin
            if (q[i].size() > 0 && q[i][0].due == adv) begin
              ev_last[i] = 1'b1;
              ed_last[i] = q[i][0].data;
              void'(q[i].pop_front());
            end else begin
              ev_last[i] = 1'b0;
            end
          end else if (fseq != last_fseq) begin
            ev_last[i] = 1'b0;
          end
          chk($sformatf("out_valid%0d", i), {31'd0, ov_w[i]}, {31'd0, ev_last[i]});
          if (ev_last[i]) chk($sformatf("out%0d", i), out_w[i], ed_last[i]);
          chk($sformatf("sel_err%0d", i), {31'd0, se_w[i]}, {31'd0, err_m[i]});
        end
      end
      last_adv  = adv;
      last_fseq = fseq;
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; bus4 = '0; sel = '0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) err_m[i] = 1'b0;

    repeat (2) @(negedge clk);
    #3 chk_reset_state("por");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Select each legal input on consecutive edges
    bus4 = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    drain(3);

    // Illegal select, set+clear collision, plain clear, non-accepted illegal selects
    cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    drain(3);

    // Values 1,2 then a two-cycle stall, then 3
    bus4[31:0] = 32'd1; cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    bus4[31:0] = 32'd2; cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    bus4[31:0] = 32'd9; cyc(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    bus4[31:0] = 32'd3; cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drain(3);

    // Both stages full, then flush together with stall, then a fresh operand
    bus4[31:0] = 32'h41; cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    bus4[31:0] = 32'h42; cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    bus4[31:0] = 32'h4F; cyc(1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    bus4[31:0] = 32'h43; cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drain(3);

    // Mid-stream asynchronous reset with operands in flight and the error flag set
    cyc(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    bus4[63:32] = 32'h5555_1111; cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    async_reset();
    bus4[95:64] = 32'h7777_2222; cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    drain(3);

    // Randomised traffic
    for (int n = 0; n < 1000; n++) begin
      bus4 = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 15) == 0));
    end
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
